// File: rtl/ss_addresses.sv
// Savestate bus address map, shared word type and bus request bundle.
// Each responder instance takes one SS_ADDR_* constant as its ADDR_BASE.
package ss_addresses;

   typedef logic [31:0] ss_word_t;

   localparam logic [7:0] SS_ADDR_CPU   = 8'h00;
   localparam logic [7:0] SS_ADDR_TIMER = 8'h10;
   localparam logic [7:0] SS_ADDR_DMA   = 8'h20;
   localparam logic [7:0] SS_ADDR_AUDIO = 8'h30;

   typedef struct packed {
      logic [7:0] addr;
      logic       wren;
      logic       rst;
      ss_word_t   dat;
   } ss_bus_req_t;

   // Window test at 9 bits so base + count never wraps past 8'hFF.
   function automatic logic ss_addr_hit(input logic [7:0] addr,
                                        input logic [7:0] base,
                                        input logic [4:0] count);
      logic [8:0] a;
      logic [8:0] lo;
      logic [8:0] hi;
      a  = {1'b0, addr};
      lo = {1'b0, base};
      hi = lo + {4'b0000, count};
      return (a >= lo) && (a < hi);
   endfunction

endpackage

// File: rtl/ss_word_bank.sv
// State word bank: address decode, write port, bulk capture and registered read mux.
// Latency: bus_out 1 cycle after the address; no backpressure, one access per cycle.
module ss_word_bank
   import ss_addresses::*;
#(
   parameter logic [7:0] ADDR_BASE  = SS_ADDR_CPU,
   parameter int         WORD_COUNT = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  ss_bus_req_t             bus_req,
   input  logic                    halted,
   input  logic                    capture,
   input  logic [WORD_COUNT*32-1:0] state_d,
   output logic [WORD_COUNT*32-1:0] state_q,
   output ss_word_t                bus_out,
   output logic                    wr_hit
);

   logic     sel;
   logic [3:0] idx;
   ss_word_t bank [WORD_COUNT];
   ss_word_t rd_word;

   assign sel    = ss_addr_hit(bus_req.addr, ADDR_BASE, 5'(WORD_COUNT));
   assign idx    = 4'(bus_req.addr - ADDR_BASE);
   assign wr_hit = halted && bus_req.wren && sel;

   always_comb begin
      rd_word = '0;
      for (int i = 0; i < WORD_COUNT; i++) begin
         if (idx == 4'(i)) rd_word = bank[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < WORD_COUNT; i++) bank[i] <= '0;
         bus_out <= '0;
      end else begin
         if (capture) begin
            for (int i = 0; i < WORD_COUNT; i++) bank[i] <= state_d[32*i +: 32];
         end else if (wr_hit) begin
            for (int i = 0; i < WORD_COUNT; i++) begin
               if (idx == 4'(i)) bank[i] <= bus_req.dat;
            end
         end
         // Unselected instances drive zero so several banks can be OR-combined.
         bus_out <= (halted && sel && !bus_req.rst) ? rd_word : '0;
      end
   end

   for (genvar g = 0; g < WORD_COUNT; g++) begin : g_state_q
      assign state_q[32*g +: 32] = bank[g];
   end

endmodule

// File: rtl/ss_bus_responder.sv
// Savestate target: halts the core at an instruction boundary, exposes its state bank, reloads on resume.
// Latency: ss_ready 2 cycles after the boundary, bus_out 1 cycle; no backpressure, bus valid only while halted.
module ss_bus_responder
   import ss_addresses::*;
#(
   parameter logic [7:0] ADDR_BASE  = SS_ADDR_CPU,
   parameter int         WORD_COUNT = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [31:0]              bus_in,
   input  logic [7:0]               bus_addr,
   input  logic                     bus_wren,
   input  logic                     bus_reset,
   output logic [31:0]              bus_out,
   input  logic                     ss_halt,
   input  logic                     ss_begin_reset,
   output logic                     ss_ready,
   input  logic                     core_boundary,
   output logic                     core_halt,
   output logic                     core_reset,
   input  logic [WORD_COUNT*32-1:0] state_d,
   output logic [WORD_COUNT*32-1:0] state_q,
   output logic                     state_load
);

   typedef enum logic [2:0] {
      ST_RUN,
      ST_STALL,
      ST_CAPTURE,
      ST_HALTED,
      ST_LOAD
   } ss_resp_state_t;

   ss_resp_state_t state;
   ss_resp_state_t state_nxt;
   ss_bus_req_t    bus_req;
   logic           dirty;
   logic           core_reset_r;
   logic           wr_hit;

   assign bus_req.addr = bus_addr;
   assign bus_req.wren = bus_wren;
   assign bus_req.rst  = bus_reset;
   assign bus_req.dat  = bus_in;

   ss_word_bank #(
      .ADDR_BASE  (ADDR_BASE),
      .WORD_COUNT (WORD_COUNT)
   ) u_bank (
      .clk     (clk),
      .reset   (reset),
      .bus_req (bus_req),
      .halted  (state == ST_HALTED),
      .capture (state == ST_CAPTURE),
      .state_d (state_d),
      .state_q (state_q),
      .bus_out (bus_out),
      .wr_hit  (wr_hit)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= ST_RUN;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN:     if (ss_halt) state_nxt = ST_STALL;
         // The core has already frozen on a boundary cycle, so capture must follow.
         ST_STALL: begin
            if (core_boundary)  state_nxt = ST_CAPTURE;
            else if (!ss_halt)  state_nxt = ST_RUN;
         end
         ST_CAPTURE: state_nxt = ST_HALTED;
         ST_HALTED:  if (!ss_halt) state_nxt = dirty ? ST_LOAD : ST_RUN;
         ST_LOAD:    state_nxt = ST_RUN;
         default:    state_nxt = ST_RUN;
      endcase
   end

   always_comb begin
      core_halt  = 1'b0;
      ss_ready   = 1'b0;
      state_load = 1'b0;
      case (state)
         ST_STALL:   core_halt = core_boundary;
         ST_CAPTURE: core_halt = 1'b1;
         ST_HALTED: begin
            core_halt = 1'b1;
            ss_ready  = 1'b1;
         end
         ST_LOAD: begin
            core_halt  = 1'b1;
            state_load = 1'b1;
         end
         default: ;
      endcase
   end
   assign core_reset = core_reset_r;

   always_ff @(posedge clk) begin
      if (reset)                                  dirty <= 1'b0;
      else if (wr_hit)                            dirty <= 1'b1;
      else if (bus_reset || state == ST_CAPTURE || state == ST_LOAD) dirty <= 1'b0;
   end

   // Held from the request until the same edge that takes the FSM out of HALTED.
   always_ff @(posedge clk) begin
      if (reset)                                        core_reset_r <= 1'b0;
      else if (state_nxt != ST_HALTED)                  core_reset_r <= 1'b0;
      else if (state == ST_HALTED && ss_begin_reset)    core_reset_r <= 1'b1;
   end

endmodule

// File: doc/ss_bus_responder.md
Name: ss_bus_responder

Overview:
- Savestate-bus target that sits inside the core, at the opposite end of the bus driven by the savestate machine.
- Answers halt requests by stalling the core at an instruction boundary and then raising ss_ready.
- While the core is halted, exposes a bank of 32-bit state words: reads drive bus_out, writes update the bank.
- After a load, pushes the written bank back into the core with a single load strobe.

Parameters:
- ADDR_BASE, 8'h00: first bus_addr word owned by this instance.
- WORD_COUNT, 4: number of 32-bit state words, 1..16.

Ports:
- clk  in  1  core system clock.
- reset  in  1  synchronous, active-high reset.
- bus_in  in  32  write data from the savestate machine.
- bus_addr  in  8  word address.
- bus_wren  in  1  write strobe, one word per cycle.
- bus_reset  in  1  start-of-transfer marker.
- bus_out  out  32  read data; 0 when not selected, so multiple instances can be OR-combined.
- ss_halt  in  1  halt request, level.
- ss_begin_reset  in  1  core-reset request, valid while halted.
- ss_ready  out  1  core halted and bank valid.
- core_boundary  in  1  core is at an instruction boundary this cycle.
- core_halt  out  1  freezes core clock enables.
- core_reset  out  1  held-reset request to the core.
- state_d  in  WORD_COUNT*32  live core state; word i is bits [32i+31:32i].
- state_q  out  WORD_COUNT*32  bank contents presented to the core.
- state_load  out  1  one-cycle pulse: the core copies state_q into its registers.

Behaviour:

Reset:
- All outputs 0.
- Bank cleared to 0.
- dirty = 0.
- FSM in RUN.

FSM states: RUN, STALL, CAPTURE, HALTED, LOAD.
- RUN:
  - core_halt = 0.
  - ss_halt = 1 → STALL.
- STALL:
  - core_halt = core_boundary (combinational), so the core freezes on the boundary cycle.
  - Registered transition: on core_boundary → CAPTURE.
  - ss_halt dropping before the boundary → RUN, with no capture.
- CAPTURE:
  - core_halt = 1.
  - Bank ← state_d (all words, single cycle).
  - dirty = 0.
  - Next state is HALTED.
- HALTED:
  - core_halt = 1, ss_ready = 1.
  - Bus accesses are accepted only in this state.
  - ss_begin_reset = 1 sets core_reset = 1. core_reset stays asserted until the FSM leaves HALTED.
  - ss_halt = 0 → LOAD if dirty, otherwise → RUN.
  - ss_ready and core_reset drop in the same cycle the FSM leaves HALTED.
- LOAD:
  - core_halt = 1.
  - state_load = 1 for exactly one cycle.
  - dirty = 0.
  - Next state is RUN.
  - core_halt drops on entry to RUN, so the core resumes one cycle after the load strobe.

Address decode:
- sel = (bus_addr >= ADDR_BASE) && (bus_addr < ADDR_BASE + WORD_COUNT).
- The comparison is done at 9-bit width, so ADDR_BASE + WORD_COUNT never wraps.
- idx = bus_addr - ADDR_BASE, truncated to 4 bits.

Read:
- bus_out is registered, 1-cycle latency: bus_out(t+1) = (HALTED && sel(t)) ? bank[idx(t)] : 0.

Write:
- In HALTED with bus_wren && sel: bank[idx] ← bus_in at the clock edge, and dirty ← 1.
- Writes outside HALTED or with sel = 0 are ignored.
- A read of the same address in the cycle after a write returns the new data.

bus_reset:
- Clears dirty and forces bus_out to 0 on the next cycle.
- Bank contents are untouched.
- If asserted in the same cycle as bus_wren, the write wins: dirty = 1.

state_q:
- Always equals the bank; driven directly from the registers.

Other cases:
- ss_halt reasserted in LOAD is ignored until RUN; STALL is re-entered on the following cycle.
- reset in any state returns to RUN immediately, without a state_load pulse.

Decomposition:
- Package ss_addresses gains per-instance base constants (for example SS_ADDR_CPU, SS_ADDR_TIMER) used as ADDR_BASE.
- The same package defines the shared typedef ss_word_t (logic [31:0]).
- The FSM state enum ss_resp_state_t stays local to the module.
- One natural sub-module, ss_word_bank: the bank registers, decode, write port and registered read mux. The FSM stays in ss_bus_responder.

Test Plan:
- Halt handshake: ss_halt = 1 while core_boundary stays low for 5 cycles, then pulses. Required: core_halt rises in the boundary cycle; ss_ready = 1 exactly 2 cycles later; bank = state_d sampled at CAPTURE.
- Read out (ADDR_BASE = 8'h10, WORD_COUNT = 4, state_d words 0xA0..0xA3): addr 0x10..0x13 in consecutive cycles gives bus_out = 0xA0..0xA3 one cycle later. addr 0x14 gives 0. addr 0x0F gives 0.
- Load: write 0xDEADBEEF to 0x12, then ss_halt = 0. Required: one LOAD cycle with state_load = 1 and state_q word 2 = 0xDEADBEEF; core_halt = 0 the next cycle.
- No-write resume: halt, read only, release. Required: no state_load pulse, straight to RUN.
- Reset request: ss_begin_reset = 1 in HALTED gives core_reset = 1 until ss_halt = 0, then it drops together with ss_ready. Writes ignored before HALTED: bank unchanged.
- Sync reset mid-STALL or mid-HALTED: all outputs 0 on the next cycle, bank = 0, no state_load.
